// File: rtl/shifter_pkg.sv
// Shared encodings and sizing for the iterative shifter, the ALUOut mux and the control unit.
package shifter_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit-position step of the iterative shifter.
module shift_step #(
    parameter int WIDTH = shifter_pkg::WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] next_r
);
    import shifter_pkg::*;

    always_comb begin
        next_r = r;
        case (op)
            SH_SLL:  next_r = {r[WIDTH-2:0], 1'b0};
            SH_SRL:  next_r = {1'b0, r[WIDTH-1:1]};
            SH_SRA:  next_r = {r[WIDTH-1], r[WIDTH-1:1]};
            SH_ROR:  next_r = {r[0], r[WIDTH-1:1]};
            default: next_r = r;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multicycle shifter: one bit position per clock; the result register holds until the next accepted start.
module iterative_shifter #(
    parameter int WIDTH   = shifter_pkg::WIDTH,
    parameter int SHAMT_W = shifter_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    import shifter_pkg::*;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   step_r;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_q),
        .r      (result_q),
        .next_r (step_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= SH_SLL;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_d = data_in;
                    count_d  = shamt;
                    op_d     = op;
                    state_d  = (shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                result_d = step_r;
                count_d  = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule
